// File: rtl/comma_align_10b_if.sv
// Line-side bundle of the comma aligner: recovered serial bit in, aligned
// code groups and lock status out.
interface comma_align_10b_if;
  logic       serial_in;
  logic [9:0] data10_out;
  logic       valid_out;
  logic       comma_out;
  logic       locked;

  // master: the line source / word consumer side
  modport master (
    output serial_in,
    input  data10_out,
    input  valid_out,
    input  comma_out,
    input  locked
  );

  // slave: the aligner itself
  modport slave (
    input  serial_in,
    output data10_out,
    output valid_out,
    output comma_out,
    output locked
  );
endinterface

// File: rtl/comma_align_10b.sv
// K28.5 comma word aligner: hunts the comma in the serial line, locks the
// 10-bit boundary and emits aligned code groups (bit0 = a ... bit9 = j).
module comma_align_10b #(
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  comma_align_10b_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);
  localparam logic [3:0] CNT_MAX  = 4'd15;

  state_t     state_q, state_d;
  logic [9:0] sr_q, sr_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [3:0] bad_cnt_q, bad_cnt_d;
  logic [9:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       comma_q, comma_d;
  logic       locked_q, locked_d;

  logic       comma_hit;
  logic       boundary;
  logic [3:0] bit_inc;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;

  // sr[0] is the oldest bit; a comma prefix at sr[6:0] means sr holds a whole word
  assign sr_d      = {bus.serial_in, sr_q[9:1]};
  assign comma_hit = (sr_q[6:0] == 7'b1111100) || (sr_q[6:0] == 7'b0000011);
  assign boundary  = (bit_cnt_q == 4'd0) && (state_q != HUNT);
  assign bit_inc   = (bit_cnt_q == 4'd9) ? 4'd0 : bit_cnt_q + 4'd1;
  assign good_inc  = (good_cnt_q == CNT_MAX) ? CNT_MAX : good_cnt_q + 4'd1;
  assign bad_inc   = (bad_cnt_q == CNT_MAX) ? CNT_MAX : bad_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_inc;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    comma_d    = comma_q;

    unique case (state_q)
      HUNT: begin
        if (comma_hit) begin
          bit_cnt_d  = 4'd1;
          good_cnt_d = 4'd1;
          if (LOCK_N == 4'd1) begin
            state_d = LOCKED;
            data_d  = sr_q;
            valid_d = 1'b1;
            comma_d = 1'b1;
          end else begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (comma_hit && boundary) begin
          good_cnt_d = good_inc;
          if (good_inc == LOCK_N) begin
            state_d = LOCKED;
            data_d  = sr_q;
            valid_d = 1'b1;
            comma_d = 1'b1;
          end
        end else if (comma_hit) begin
          // comma off the tentative boundary: restart qualification at its phase
          bit_cnt_d  = 4'd1;
          good_cnt_d = 4'd1;
        end
      end

      LOCKED: begin
        if (boundary) begin
          data_d  = sr_q;
          valid_d = 1'b1;
          comma_d = comma_hit;
          if (comma_hit) begin
            bad_cnt_d = 4'd0;
          end
        end else if (comma_hit) begin
          bad_cnt_d = bad_inc;
          if (bad_inc == UNLOCK_N) begin
            state_d    = HUNT;
            bad_cnt_d  = 4'd0;
            good_cnt_d = 4'd0;
          end
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q    <= HUNT;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      comma_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      comma_q    <= comma_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.data10_out = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.comma_out  = comma_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_comma_align_10b.sv
// Bench for comma_align_10b: directed scenarios plus a randomized word stream,
// every cycle compared against a history-based reference model.
module tb_comma_align_10b;

  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 4;
  localparam logic [9:0] K_NEG = 10'h17C;
  localparam logic [9:0] K_POS = 10'h283;
  localparam logic [9:0] D215  = 10'h155;

  logic clk = 1'b0;
  logic reset_L = 1'b0;

  comma_align_10b_if bus_if ();

  comma_align_10b #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: full bit history, boundary tracked as an anchor time
  bit         hist[$];
  int         n_cyc = 0;
  int         anchor = 0;
  int         mode = 0;   // 0 hunting, 1 qualifying, 2 locked
  int         good = 0;
  int         bad = 0;
  logic [9:0] m_data = '0;
  logic       m_valid = 1'b0;
  logic       m_comma = 1'b0;
  logic       m_locked = 1'b0;
  bit         started = 1'b0;

  // DUT pulse log for the literal pins
  logic [10:0] pulses[$];

  function automatic logic [9:0] window();
    logic [9:0] w;
    int sz;
    w = '0;
    sz = hist.size();
    for (int i = 0; i < 10; i++)
      if (sz - 10 + i >= 0) w[i] = hist[sz - 10 + i];
    return w;
  endfunction

  function automatic bit is_comma(input logic [9:0] w);
    // a,b,c,d,e,i,f of K28.5 in either running disparity
    return (w[0] == w[1]) && (w[2] != w[1]) &&
           (w[2] == w[3]) && (w[3] == w[4]) && (w[4] == w[5]) && (w[5] == w[6]);
  endfunction

  always @(posedge clk) begin
    logic [9:0] w;
    bit hit, on_bnd;
    if (!reset_L) begin
      hist.delete();
      n_cyc = 0; anchor = 0; mode = 0; good = 0; bad = 0;
      m_data = '0; m_valid = 1'b0; m_comma = 1'b0; m_locked = 1'b0;
      started = 1'b1;
    end else begin
      w = window();
      hit = is_comma(w);
      on_bnd = (mode != 0) && (n_cyc > anchor) && (((n_cyc - anchor) % 10) == 0);
      m_valid = 1'b0;
      if (mode == 0) begin
        if (hit) begin
          anchor = n_cyc; good = 1;
          if (LOCK_CNT == 1) begin
            mode = 2; m_data = w; m_valid = 1'b1; m_comma = 1'b1;
          end else mode = 1;
        end
      end else if (mode == 1) begin
        if (hit && on_bnd) begin
          good = (good < 15) ? good + 1 : 15;
          if (good == LOCK_CNT) begin
            mode = 2; m_data = w; m_valid = 1'b1; m_comma = 1'b1;
          end
        end else if (hit) begin
          anchor = n_cyc; good = 1;
        end
      end else begin
        if (on_bnd) begin
          m_data = w; m_valid = 1'b1; m_comma = hit;
          if (hit) bad = 0;
        end else if (hit) begin
          bad = (bad < 15) ? bad + 1 : 15;
          if (bad == UNLOCK_CNT) begin
            mode = 0; bad = 0; good = 0;
          end
        end
      end
      m_locked = (mode == 2);
      hist.push_back(bus_if.serial_in);
      if (hist.size() > 16) void'(hist.pop_front());
      n_cyc++;
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (bus_if.valid_out !== m_valid || bus_if.comma_out !== m_comma ||
          bus_if.locked !== m_locked || bus_if.data10_out !== m_data) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t got v=%0b c=%0b l=%0b d=%h want v=%0b c=%0b l=%0b d=%h",
                 $time, bus_if.valid_out, bus_if.comma_out, bus_if.locked, bus_if.data10_out,
                 m_valid, m_comma, m_locked, m_data);
      end
      if (bus_if.valid_out === 1'b1) begin
        pulses.push_back({bus_if.comma_out, bus_if.data10_out});
        $display("word t=%0t data=%h comma=%0b locked=%0b", $time,
                 bus_if.data10_out, bus_if.comma_out, bus_if.locked);
      end
    end
  end

  task automatic pin(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic rst_n);
    @(negedge clk);
    bus_if.serial_in = b;
    reset_L = rst_n;
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic send_word(input logic [9:0] w, input int rst_at);
    for (int i = 0; i < 10; i++) begin
      send_bit(w[i], (i == rst_at) ? 1'b0 : 1'b1);
      if (i == rst_at) begin
        pin("rst_clear_valid", int'(bus_if.valid_out), 0);
        pin("rst_clear_data", int'(bus_if.data10_out), 0);
        pin("rst_clear_locked", int'(bus_if.locked), 0);
      end
    end
  endtask

  task automatic do_reset();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
  endtask

  task automatic send_rand_bits(input int cnt);
    for (int i = 0; i < cnt; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic lock_stream_pins(input string tag);
    pin({tag, "_pulses"}, pulses.size(), 5);
    if (pulses.size() >= 2) begin
      pin({tag, "_first"}, int'(pulses[0]), int'({1'b1, K_NEG}));
      pin({tag, "_second"}, int'(pulses[1]), int'({1'b0, D215}));
    end
    pin({tag, "_locked"}, int'(bus_if.locked), 1);
  endtask

  initial begin
    bus_if.serial_in = 1'b0;
    reset_L = 1'b0;

    // 1: reset with toggling line, then an idle line never locks
    do_reset();
    pin("t1_reset_valid", int'(bus_if.valid_out), 0);
    pin("t1_reset_data", int'(bus_if.data10_out), 0);
    for (int i = 0; i < 40; i++) send_bit(1'b0, 1'b1);
    pin("t1_idle_locked", int'(bus_if.locked), 0);
    pin("t1_model_locked", int'(m_locked), 0);

    // 2: three commas then D21.5
    pulses.delete();
    for (int i = 0; i < 3; i++) send_word(K_NEG, -1);
    for (int i = 0; i < 5; i++) send_word(D215, -1);
    lock_stream_pins("t2");
    pin("t2_model_data", int'(m_data), int'(D215));

    // 3: same stream behind 4 random bits
    do_reset();
    pulses.delete();
    send_rand_bits(4);
    for (int i = 0; i < 3; i++) send_word(K_NEG, -1);
    for (int i = 0; i < 5; i++) send_word(D215, -1);
    lock_stream_pins("t3");

    // 4: alternating disparity commas
    do_reset();
    pulses.delete();
    for (int i = 0; i < 6; i++) send_word((i % 2 == 0) ? K_NEG : K_POS, -1);
    pin("t4_pulses", pulses.size(), 3);
    if (pulses.size() >= 2) begin
      pin("t4_first", int'(pulses[0]), int'({1'b1, K_NEG}));
      pin("t4_second", int'(pulses[1]), int'({1'b1, K_POS}));
    end

    // 5: four slipped commas drop lock, then re-lock at the new phase
    for (int s = 0; s < 4; s++) begin
      send_rand_bits(3);
      send_word(K_NEG, -1);
      send_word(D215, -1);
      if (s == 2) pin("t5_hold_after_3", int'(bus_if.locked), 1);
    end
    pin("t5_drop_after_4", int'(bus_if.locked), 0);
    for (int i = 0; i < 3; i++) send_word(K_NEG, -1);
    send_word(D215, -1);
    pin("t5_relock", int'(bus_if.locked), 1);

    // 6: one-cycle reset mid-lock
    for (int i = 0; i < 2; i++) send_word(D215, -1);
    send_word(D215, 4);
    send_word(D215, -1);
    send_word(K_NEG, -1);
    send_word(K_NEG, -1);
    send_word(D215, -1);
    pin("t6_two_commas_unlocked", int'(bus_if.locked), 0);
    send_word(K_NEG, -1);
    send_word(D215, -1);
    pin("t6_relocked", int'(bus_if.locked), 1);

    // randomized stream: commas, data, slips, junk, rare resets
    for (int k = 0; k < 300; k++) begin
      int kind;
      logic [9:0] rw;
      kind = $urandom_range(0, 39);
      rw = 10'($urandom);
      if (kind < 12)      send_word((kind % 2 == 0) ? K_NEG : K_POS, -1);
      else if (kind < 28) send_word(D215, -1);
      else if (kind < 34) send_word(rw, -1);
      else if (kind < 39) begin
        send_rand_bits($urandom_range(1, 9));
        send_word(K_NEG, -1);
      end else send_word(D215, $urandom_range(0, 9));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comma_align_10b.md
Name: comma_align_10b

Overview:
- Receive-side word aligner that sits directly upstream of the 10b-to-8b decoder.
- Takes the recovered serial line one bit per clk and hunts for the K28.5 comma.
- Locks the 10-bit word boundary and presents aligned words on a 10-bit bus, in the same bit order the decoder expects: bit0 = a … bit9 = j.
- Provides lock and word-valid status for downstream framing.

Parameters:
- LOCK_CNT, 3: consecutive boundary-aligned commas required to declare lock (legal 1..15).
- UNLOCK_CNT, 4: misaligned commas seen while locked before lock is dropped (legal 1..15).

Ports:
- clk  input  1  receive clock, one line bit per rising edge.
- reset_L  input  1  synchronous active-low reset.
- serial_in  input  1  recovered line bit; first transmitted bit (a) arrives first.
- data10_out  output  10  aligned code group, [0]=a,[1]=b,[2]=c,[3]=d,[4]=e,[5]=i,[6]=f,[7]=g,[8]=h,[9]=j.
- valid_out  output  1  one-cycle strobe: data10_out holds a new word.
- comma_out  output  1  qualifies valid_out: current word is a comma.
- locked  output  1  high while in LOCKED state.

Behaviour:
- Reset: one clk, reset_L low, sampled on the rising edge. It clears sr (10-bit shift register) to 0, data10_out to 0, valid_out/comma_out/locked to 0, bit_cnt/good_cnt/bad_cnt to 0, and sets the state to HUNT. Reset mid-word or mid-lock discards everything and lock must be re-acquired.
- Shift: every edge, sr <= {serial_in, sr[9:1]}, so sr[0] is the oldest bit (a).
- comma_hit (combinational) = sr[6:0]==7'b1111100 or sr[6:0]==7'b0000011. This is the a,b,c,d,e,i,f comma prefix in both polarities. When comma_hit is high, sr holds a complete candidate word.
- bit_cnt (0..9, 4-bit):
  - On an acceptance in HUNT (comma_hit high), bit_cnt <= 1.
  - Otherwise bit_cnt <= (bit_cnt==9) ? 0 : bit_cnt+1.
  - boundary = (bit_cnt==0) and state != HUNT. At a boundary, sr holds an aligned word.
- HUNT:
  - comma_hit: accept. bit_cnt <= 1, good_cnt <= 1. Go to LOCKED if LOCK_CNT==1 (comma word is output, see below), else go to CHECK.
  - Otherwise stay in HUNT. No valid_out.
- CHECK:
  - boundary and comma_hit: good_cnt++. When good_cnt+1 == LOCK_CNT, go to LOCKED.
  - boundary and no comma: stay in CHECK; good_cnt unchanged (data between commas is legal).
  - comma_hit off boundary: realign immediately, as if accepted from HUNT (bit_cnt <= 1, good_cnt <= 1, stay in CHECK).
  - No valid_out in CHECK.
- LOCKED:
  - Every boundary: data10_out <= sr, valid_out <= 1, comma_out <= comma_hit, bad_cnt cleared if comma_hit.
  - The boundary cycle that causes the transition into LOCKED also outputs its comma word.
  - comma_hit off boundary: bad_cnt++. When bad_cnt+1 == UNLOCK_CNT, go to HUNT and clear bad_cnt/good_cnt. No output for that cycle. The misaligned comma is not re-accepted in the same cycle; the next comma is needed.
- Timing:
  - Latency: the word is complete in sr at the boundary cycle, and data10_out/valid_out update on the next edge (1 clk).
  - valid_out is a single-cycle pulse exactly every 10 clks while locked.
  - data10_out holds its value between pulses.
- locked is registered: it goes high on the same edge as the first valid_out and falls on the edge that enters HUNT.
- Counters saturate at 15 and never wrap.

Test Plan:
1. Reset_L=0 for 2 clks with serial_in toggling -> all outputs 0, no valid_out; after release with all-zero line, locked stays 0 indefinitely.
2. Send K28.5 RD- (word 0x17C) three times back-to-back, then D21.5 (0x155) repeated, LOCK_CNT=3 -> locked rises with valid_out, data10_out=0x17C, comma_out=1. Then valid_out pulses every 10 clks with 0x155, comma_out=0.
3. Prepend 4 random bits before the stream of test 2 -> identical outputs, shifted 4 clks later; data10_out never shows a misaligned word.
4. Alternate K28.5 RD- (0x17C) and RD+ (0x283) -> locks after 3 commas; comma_out=1 on every pulse, with values alternating 0x17C/0x283.
5. While locked, insert 3 extra bits before each of 4 subsequent commas (UNLOCK_CNT=4) -> locked stays high through 3 slips. It drops on the 4th misaligned comma; the next comma starts HUNT/CHECK and re-lock occurs at the new phase.
6. Assert reset_L=0 for 1 clk mid-lock, then resume the comma/data stream -> outputs clear the next edge, and re-lock requires LOCK_CNT fresh aligned commas.
